// File: rtl/axis_out_packer_pkg.sv
// Shared defaults for the M_AXIS output packer and its word FIFO.
// Latency: n/a (constants only).
// Backpressure: n/a.
package axis_out_packer_pkg;

    localparam int DEF_ELEM_WIDTH    = 8;
    localparam int DEF_TDATA_WIDTH   = 32;
    localparam int DEF_FIFO_DEPTH    = 4;
    localparam int DEF_PKT_LEN_WIDTH = 16;

    // Lane counter width; at least one bit even when a word holds a single element.
    function automatic int lane_bits(input int pack);
        return (pack > 1) ? $clog2(pack) : 1;
    endfunction

endpackage

// File: rtl/axis_fifo_sync.sv
// Show-ahead synchronous FIFO holding packed M_AXIS words {tlast, tstrb, tdata}.
// Latency: a pushed word is visible on pop_dat the cycle after the push.
// Backpressure: push is ignored when full; the reader holds the head until pop.
// Ports: clk/rst_n, clear (sync flush), push/push_dat, pop/pop_dat, full/empty/level.
module axis_fifo_sync #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    // One extra pointer bit distinguishes full from empty; pointers wrap naturally.
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign level   = wr_ptr_q - rd_ptr_q;
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (level == (AW+1)'(DEPTH));
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;

    // Head is forced to zero when empty so the output bus idles at 0.
    assign pop_dat = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/axis_out_packer.sv
// Packs narrow result elements into M_AXIS words with TSTRB/TLAST and buffers them in a FIFO.
// Latency: completing element at cycle N gives M_AXIS_TVALID at N+1.
// Backpressure: in_ready = !fifo_full (registered, no path from TREADY); drops set sticky overflow.
// Ports: clk/rst_n/clear; in_valid/in_data/in_last/in_ready; pkt_len; M_AXIS_*; overflow, fifo_level, busy.
import axis_out_packer_pkg::*;

module axis_out_packer #(
    parameter int ELEM_WIDTH           = DEF_ELEM_WIDTH,
    parameter int C_M_AXIS_TDATA_WIDTH = DEF_TDATA_WIDTH,
    parameter int FIFO_DEPTH           = DEF_FIFO_DEPTH,
    parameter int PKT_LEN_WIDTH        = DEF_PKT_LEN_WIDTH
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                clear,
    input  logic                                in_valid,
    input  logic [ELEM_WIDTH-1:0]               in_data,
    input  logic                                in_last,
    output logic                                in_ready,
    input  logic [PKT_LEN_WIDTH-1:0]            pkt_len,
    input  logic                                M_AXIS_TREADY,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
    output logic                                M_AXIS_TVALID,
    output logic                                M_AXIS_TLAST,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
    output logic                                overflow,
    output logic [$clog2(FIFO_DEPTH):0]         fifo_level,
    output logic                                busy
);

    localparam int TW     = C_M_AXIS_TDATA_WIDTH;
    localparam int SW     = TW / 8;
    localparam int PACK   = TW / ELEM_WIDTH;
    localparam int EB     = ELEM_WIDTH / 8;
    localparam int LANE_W = lane_bits(PACK);
    localparam int FW     = TW + SW + 1;

    logic [LANE_W-1:0]        lane_idx_q;
    logic [TW-1:0]            pack_buf_q;
    logic [PKT_LEN_WIDTH-1:0] word_cnt_q;
    logic [PKT_LEN_WIDTH-1:0] pkt_len_q;
    logic                     overflow_q;

    logic                     fifo_full;
    logic                     fifo_empty;
    logic [FW-1:0]            fifo_dout;

    logic                     accept;
    logic                     complete;
    logic                     first_elem;
    logic [PKT_LEN_WIDTH-1:0] eff_len;
    logic                     word_last;
    logic [TW-1:0]            merged;
    logic [SW-1:0]            strb;

    assign in_ready   = !fifo_full;
    assign accept     = in_valid && in_ready && !clear;
    assign complete   = accept && (in_last || (lane_idx_q == LANE_W'(PACK-1)));
    assign first_elem = (word_cnt_q == '0) && (lane_idx_q == '0);

    // The first element of a packet uses the live pkt_len, since pkt_len_q only
    // captures it at that same edge; later words use the captured value.
    assign eff_len   = first_elem ? pkt_len : pkt_len_q;
    assign word_last = in_last ||
                       ((eff_len != '0) && (word_cnt_q == eff_len - PKT_LEN_WIDTH'(1)));

    // Lanes above lane_idx in pack_buf are always zero, so merging is a lane write.
    always_comb begin
        merged = pack_buf_q;
        strb   = '0;
        for (int l = 0; l < PACK; l++) begin
            if (lane_idx_q == LANE_W'(l)) begin
                merged[l*ELEM_WIDTH +: ELEM_WIDTH] = in_data;
            end
            if (LANE_W'(l) <= lane_idx_q) begin
                strb[l*EB +: EB] = '1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_idx_q <= '0;
            pack_buf_q <= '0;
            word_cnt_q <= '0;
            pkt_len_q  <= '0;
            overflow_q <= 1'b0;
        end else if (clear) begin
            lane_idx_q <= '0;
            pack_buf_q <= '0;
            word_cnt_q <= '0;
            pkt_len_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (in_valid && !in_ready) begin
                overflow_q <= 1'b1;
            end
            if (accept && first_elem) begin
                pkt_len_q <= pkt_len;
            end
            if (complete) begin
                lane_idx_q <= '0;
                pack_buf_q <= '0;
                word_cnt_q <= word_last ? '0 : word_cnt_q + PKT_LEN_WIDTH'(1);
            end else if (accept) begin
                lane_idx_q <= lane_idx_q + LANE_W'(1);
                pack_buf_q <= merged;
            end
        end
    end

    axis_fifo_sync #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .push     (complete),
        .push_dat ({word_last, strb, merged}),
        .pop      (M_AXIS_TREADY),
        .pop_dat  (fifo_dout),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    assign M_AXIS_TVALID = !fifo_empty;
    assign M_AXIS_TDATA  = fifo_dout[TW-1:0];
    assign M_AXIS_TSTRB  = fifo_dout[TW +: SW];
    assign M_AXIS_TLAST  = fifo_dout[FW-1];
    assign overflow      = overflow_q;
    assign busy          = !fifo_empty || (lane_idx_q != '0);

endmodule

// File: tb/tb_axis_out_packer.sv
// Directed bench for axis_out_packer: stimulus pushes expected words, a monitor pops and compares.
// Latency: checks TVALID one cycle after the completing element.
// Backpressure: exercises TREADY low, FIFO full, drop/overflow, clear and async reset.
module tb_axis_out_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [15:0] pkt_len = '0;
    logic        M_AXIS_TREADY = 1'b1;
    logic [31:0] M_AXIS_TDATA;
    logic        M_AXIS_TVALID;
    logic        M_AXIS_TLAST;
    logic [3:0]  M_AXIS_TSTRB;
    logic        overflow;
    logic [2:0]  fifo_level;
    logic        busy;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  s;
        logic        l;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    axis_out_packer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (clear),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_last       (in_last),
        .in_ready      (in_ready),
        .pkt_len       (pkt_len),
        .M_AXIS_TREADY (M_AXIS_TREADY),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
        .M_AXIS_TSTRB  (M_AXIS_TSTRB),
        .overflow      (overflow),
        .fifo_level    (fifo_level),
        .busy          (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [3:0] s, input logic l);
        exp_t e;
        e.d = d; e.s = s; e.l = l;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Monitor: a beat transfers at the next posedge when TVALID&TREADY here.
    always @(negedge clk) begin
        if (rst_n && M_AXIS_TVALID && M_AXIS_TREADY) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", {32'h0, M_AXIS_TDATA}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("tdata", {32'h0, M_AXIS_TDATA}, {32'h0, e.d});
                check("tstrb", {60'h0, M_AXIS_TSTRB}, {60'h0, e.s});
                check("tlast", {63'h0, M_AXIS_TLAST}, {63'h0, e.l});
            end
        end
    end

    initial begin
        // Reset state
        #12;
        check("rst_tvalid",   {63'h0, M_AXIS_TVALID}, 64'd0);
        check("rst_tlast",    {63'h0, M_AXIS_TLAST},  64'd0);
        check("rst_overflow", {63'h0, overflow},      64'd0);
        check("rst_busy",     {63'h0, busy},          64'd0);
        check("rst_tdata",    {32'h0, M_AXIS_TDATA},  64'd0);
        check("rst_tstrb",    {60'h0, M_AXIS_TSTRB},  64'd0);
        check("rst_level",    {61'h0, fifo_level},    64'd0);
        check("rst_in_ready", {63'h0, in_ready},      64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: full word, latency
        expect_word(32'h4433_2211, 4'hF, 1'b0);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        check("t1_busy_partial", {63'h0, busy},          64'd1);
        check("t1_tvalid_early", {63'h0, M_AXIS_TVALID}, 64'd0);
        send(8'h44, 1'b0);
        check("t1_tvalid_n1",    {63'h0, M_AXIS_TVALID}, 64'd1);
        repeat (2) @(posedge clk);
        #1;

        // 2: partial word on in_last, next element back in lane 0
        expect_word(32'h0000_A2A1, 4'h3, 1'b1);
        expect_word(32'h0000_00B1, 4'h1, 1'b1);
        send(8'hA1, 1'b0);
        send(8'hA2, 1'b1);
        send(8'hB1, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        // 3: pkt_len=2, mid-packet changes ignored
        pkt_len = 16'd2;
        expect_word(32'h1312_1110, 4'hF, 1'b0);
        expect_word(32'h1716_1514, 4'hF, 1'b1);
        expect_word(32'h1B1A_1918, 4'hF, 1'b0);
        expect_word(32'h1F1E_1D1C, 4'hF, 1'b1);
        for (int i = 0; i < 16; i++) begin
            if (i == 5)  pkt_len = 16'd5;
            if (i == 8)  pkt_len = 16'd2;
            if (i == 10) pkt_len = 16'd5;
            send(8'h10 + 8'(i), 1'b0);
        end
        pkt_len = 16'd0;
        repeat (3) @(posedge clk);
        #1;

        // 4: fill with TREADY low, drop 17th, then drain
        M_AXIS_TREADY = 1'b0;
        expect_word(32'h4342_4140, 4'hF, 1'b0);
        expect_word(32'h4746_4544, 4'hF, 1'b0);
        expect_word(32'h4B4A_4948, 4'hF, 1'b0);
        expect_word(32'h4F4E_4D4C, 4'hF, 1'b0);
        in_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_data = 8'h40 + 8'(i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("t4_level",     {61'h0, fifo_level},   64'd4);
        check("t4_in_ready",  {63'h0, in_ready},     64'd0);
        check("t4_overflow",  {63'h0, overflow},     64'd1);
        check("t4_tdata_hd",  {32'h0, M_AXIS_TDATA}, 64'h4342_4140);
        repeat (3) @(posedge clk);
        #1;
        check("t4_tdata_hold", {32'h0, M_AXIS_TDATA}, 64'h4342_4140);
        check("t4_tlast_hold", {63'h0, M_AXIS_TLAST}, 64'd0);
        M_AXIS_TREADY = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t4_level_3pop", {61'h0, fifo_level},    64'd1);
        @(posedge clk); #1;
        check("t4_level_4pop", {61'h0, fifo_level},    64'd0);
        check("t4_drained",    {63'h0, M_AXIS_TVALID}, 64'd0);

        // 5: clear drops partial word and overflow
        send(8'h51, 1'b0);
        send(8'h52, 1'b0);
        send(8'h53, 1'b0);
        check("t5_busy_pre",     {63'h0, busy},     64'd1);
        check("t5_overflow_pre", {63'h0, overflow}, 64'd1);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check("t5_busy",     {63'h0, busy},       64'd0);
        check("t5_overflow", {63'h0, overflow},   64'd0);
        check("t5_level",    {61'h0, fifo_level}, 64'd0);
        expect_word(32'h0403_0201, 4'hF, 1'b0);
        for (int i = 1; i <= 4; i++) send(8'(i), 1'b0);
        repeat (3) @(posedge clk);
        #1;

        // 6: async reset mid-cycle with 2 words queued
        M_AXIS_TREADY = 1'b0;
        for (int i = 0; i < 8; i++) send(8'h61 + 8'(i), 1'b0);
        check("t6_level_pre", {61'h0, fifo_level}, 64'd2);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_tvalid", {63'h0, M_AXIS_TVALID}, 64'd0);
        check("t6_level",  {61'h0, fifo_level},    64'd0);
        check("t6_busy",   {63'h0, busy},          64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("t6_in_ready", {63'h0, in_ready},      64'd1);
        check("t6_tvalid_post", {63'h0, M_AXIS_TVALID}, 64'd0);
        M_AXIS_TREADY = 1'b1;
        expect_word(32'h7473_7271, 4'hF, 1'b0);
        for (int i = 0; i < 4; i++) send(8'h71 + 8'(i), 1'b0);

        // Wait for scoreboard to drain, bounded
        for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
